instr_ram_loader: RTL and testbench
===================================

INSTR_RAM_LOADER -- requirements
Module: instr_ram_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction RAM address width.
REQ-002 SHALL have parameter BASE_ADDR, default 0, first RAM address written.
REQ-003 SHALL use one clock; reset is asynchronous and active-high; ports clk and rst.
REQ-004 clk  input  1  rising-edge clock, shared with CPU1.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  single-cycle pulse; begins a load session.
REQ-007 byte_valid  input  1  byte_data holds a valid stream byte.
REQ-008 byte_data  input  8  program stream byte.
REQ-009 byte_last  input  1  qualifies the final byte of the stream.
REQ-010 byte_ready  output  1  loader accepts the byte this cycle.
REQ-011 ram_enable, ram_write_en, ram_read_en  output  1 each  instruction RAM controls.
REQ-012 ram_addr  output  ADDR_W  instruction RAM write address.
REQ-013 ram_wdata  output  16  {opcode[4:0], addr_mode[2:0], data[7:0]}.
REQ-014 cpu_hold  output  1  holds the CPU program counter while high.
REQ-015 done, error  output  1 each  session status flags, sticky until next start.
REQ-016 word_count  output  ADDR_W+1  number of words written this session.

Function
REQ-017 SHALL implement FSM states IDLE, GET_HI, GET_LO, WRITE, DONE, ERR.
REQ-018 IDLE: byte_ready=0; start -> GET_HI, clears done/error/word_count, sets ram_addr=BASE_ADDR, cpu_hold=1.
REQ-019 Transfer occurs only when byte_valid && byte_ready; byte_ready=1 only in GET_HI/GET_LO.
REQ-020 GET_HI transfer latches the byte as {opcode, addr_mode} -> GET_LO.
REQ-021 GET_LO transfer latches the data byte -> WRITE.
REQ-022 WRITE lasts exactly one cycle: ram_enable=1, ram_write_en=1, ram_read_en=0, ram_wdata stable; then ram_addr and word_count each increment by 1.
REQ-023 After WRITE: -> DONE if the GET_LO byte carried byte_last, else -> GET_HI.
REQ-024 byte_last on a GET_HI transfer (odd stream length) -> ERR; no write for the partial word.
REQ-025 A WRITE at ram_addr = 2^ADDR_W-1 without byte_last -> ERR (no wrap-around; address 0 is never overwritten).
REQ-026 DONE/ERR: cpu_hold=0 and done=1 (DONE) or error=1 (ERR); start -> new session as from IDLE.
REQ-027 start outside IDLE/DONE/ERR SHALL be ignored.
REQ-028 Outside WRITE: ram_enable=1, ram_read_en=1, ram_write_en=0 so the CPU fetch path reads normally.
REQ-029 Minimum latency: two accepted bytes to write strobe = 1 cycle; 3 cycles per word at full rate.

Reset
REQ-030 rst SHALL force IDLE, ram_addr=BASE_ADDR, word_count=0, done=0, error=0, cpu_hold=0, ram_write_en=0, ram_enable=1, ram_read_en=1, ram_wdata=0.
REQ-031 rst mid-session SHALL abort immediately; the RAM keeps words already written and no partial word is written.

Configuration
REQ-032 With LOADER_CHECKSUM_EN defined: after the last word, one additional byte (the 8-bit two's-complement sum of all previous stream bytes, so total sum == 0) is required; byte_last then marks the checksum byte; a mismatch -> ERR; a new state CHECK sits between WRITE and DONE.
REQ-033 Without LOADER_CHECKSUM_EN: no checksum byte, no CHECK state; byte_last on the data byte ends the session.

Structure
REQ-034 A shared package cpu1_pkg SHALL hold the opcode width (5), addr-mode width (3), data width (8), the instruction word typedef and the loader state enum.
REQ-035 The checksum accumulator SHALL be the single sub-module loader_csum (clear, add byte, zero-check), instantiated only under LOADER_CHECKSUM_EN.

Verification
REQ-036 Reset, then start with bytes 0x21,0x05,0x40,0xFF(last) -> RAM[0]=0x2105, RAM[1]=0x40FF, word_count=2, done=1, cpu_hold=0.
REQ-037 byte_valid toggled every other cycle -> identical RAM contents; no byte is lost or duplicated.
REQ-038 Three bytes with last on the third -> error=1, exactly one word written, ram_write_en never asserted afterwards.
REQ-039 ADDR_W=3, ten words without last -> writes at addresses 0..7, error=1, RAM[0] unchanged.
REQ-040 rst asserted in GET_LO of word 2 -> outputs take reset values within the same cycle; RAM[0] retained.
REQ-041 LOADER_CHECKSUM_EN: stream 0x21,0x05,0xDA(last) -> done=1; checksum byte 0xDB instead -> error=1.

Source files
------------

// File: rtl/cpu1_pkg.sv
// cpu1_pkg: CPU1 instruction word and loader state types (LOADER_CHECKSUM_EN adds CHECK)
package cpu1_pkg;
  localparam int OPC_W = 5;
  localparam int MODE_W = 3;
  localparam int DATA_W = 8;
  localparam int INSTR_W = OPC_W + MODE_W + DATA_W;
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [MODE_W-1:0] addr_mode;
    logic [DATA_W-1:0] data;
  } instr_t;
  typedef enum logic [2:0] {
    IDLE,
    GET_HI,
    GET_LO,
    WRITE,
    DONE,
    ERR
`ifdef LOADER_CHECKSUM_EN
    , CHECK
`endif
  } loader_state_t;
endpackage

// File: rtl/loader_csum.sv
// loader_csum: running 8-bit stream sum with zero check, used only when LOADER_CHECKSUM_EN is defined
`ifdef LOADER_CHECKSUM_EN
module loader_csum
  import cpu1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add,
  input  logic [DATA_W-1:0] byte_in,
  output logic              zero
);
  logic [DATA_W-1:0] sum;
  // accumulate every accepted byte, restarting at each new session
  always_ff @(posedge clk or posedge rst)
    if (rst) sum <= '0;
    else if (clear) sum <= '0;
    else if (add) sum <= sum + byte_in;
  assign zero = sum == '0;
endmodule
`endif

// File: rtl/instr_ram_loader.sv
// instr_ram_loader: packs a byte stream into 16-bit words for CPU1 instruction RAM while holding the CPU; LOADER_CHECKSUM_EN adds a trailing checksum byte
module instr_ram_loader
  import cpu1_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [DATA_W-1:0]  byte_data,
  input  logic               byte_last,
  output logic               byte_ready,
  output logic               ram_enable,
  output logic               ram_write_en,
  output logic               ram_read_en,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [INSTR_W-1:0] ram_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    word_count
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  loader_state_t state, state_n;
  instr_t word;
  logic xfer, start_ok, top;
`ifdef LOADER_CHECKSUM_EN
  logic full, sum_zero;
`else
  logic last_q;
`endif
  assign xfer = byte_valid && byte_ready;
  assign start_ok = start && (state == IDLE || state == DONE || state == ERR);
  assign top = ram_addr == '1;
  // state register; reset aborts a session on the spot
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state; start is only honoured while no session is running
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERR: state_n = start ? GET_HI : state;
`ifdef LOADER_CHECKSUM_EN
      GET_HI: state_n = !xfer ? state : byte_last ? CHECK : full ? ERR : GET_LO;
      GET_LO: state_n = !xfer ? state : byte_last ? ERR : WRITE;
      WRITE:  state_n = GET_HI;
      CHECK:  state_n = sum_zero ? DONE : ERR;
`else
      GET_HI: state_n = !xfer ? state : byte_last ? ERR : GET_LO;
      GET_LO: state_n = !xfer ? state : WRITE;
      WRITE:  state_n = last_q ? DONE : top ? ERR : GET_HI;
`endif
      default: state_n = IDLE;
    endcase
  end
  // byte capture, write address and word counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      word <= '0;
      ram_addr <= BASE;
      word_count <= '0;
    end else begin
      if (start_ok) begin
        ram_addr <= BASE;
        word_count <= '0;
      end
      if (state == GET_HI && xfer) {word.opcode, word.addr_mode} <= byte_data;
      if (state == GET_LO && xfer) word.data <= byte_data;
      if (state == WRITE) begin
        ram_addr <= ram_addr + ADDR_W'(1);
        word_count <= word_count + (ADDR_W+1)'(1);
      end
    end
`ifdef LOADER_CHECKSUM_EN
  // once the top address is written only the checksum byte may follow
  always_ff @(posedge clk or posedge rst)
    if (rst) full <= 1'b0;
    else if (start_ok) full <= 1'b0;
    else if (state == WRITE && top) full <= 1'b1;
  loader_csum u_csum (
    .clk,
    .rst,
    .clear(start_ok),
    .add(xfer),
    .byte_in(byte_data),
    .zero(sum_zero)
  );
`else
  // remember whether the word about to be written ends the stream
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b0;
    else if (state == GET_LO && xfer) last_q <= byte_last;
`endif
  assign byte_ready = state == GET_HI || state == GET_LO;
  assign ram_enable = 1'b1;
  assign ram_write_en = state == WRITE;
  assign ram_read_en = !ram_write_en;
  assign cpu_hold = !(state == IDLE || state == DONE || state == ERR);
  assign done = state == DONE;
  assign error = state == ERR;
  assign ram_wdata = word;
endmodule

// File: tb/tb_instr_ram_loader.sv
// tb_instr_ram_loader: table-driven, directed and random stream checks against a stream-level model (honours LOADER_CHECKSUM_EN)
module tb_instr_ram_loader;
  logic clk = 0, rst = 1;
  logic start8 = 0, start3 = 0, byte_valid = 0, byte_last = 0;
  logic [7:0] byte_data = 0;
  logic rdy8, en8, we8, re8, hold8, done8, err8;
  logic [7:0] addr8;
  logic [15:0] wd8;
  logic [8:0] wc8;
  logic rdy3, en3, we3, re3, hold3, done3, err3;
  logic [2:0] addr3;
  logic [15:0] wd3;
  logic [3:0] wc3;
  int checks = 0, errors = 0;
  int a8q[$], a3q[$], ea[$];
  logic [15:0] d8q[$], d3q[$], ed[$];
  bit e_done, e_err;
  logic [7:0] sb[0:63];
  bit sl[0:63];
  typedef struct {
    int n;
    logic [63:0] bytes;
    logic [7:0] lastm;
    bit gap;
    bit e_done;
    bit e_err;
    int e_wc;
    logic [15:0] w0;
    logic [15:0] w1;
  } vec_t;
  vec_t tbl[$];

  instr_ram_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start8), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(rdy8), .ram_enable(en8), .ram_write_en(we8),
    .ram_read_en(re8), .ram_addr(addr8), .ram_wdata(wd8), .cpu_hold(hold8), .done(done8),
    .error(err8), .word_count(wc8)
  );
  instr_ram_loader #(.ADDR_W(3), .BASE_ADDR(0)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(rdy3), .ram_enable(en3), .ram_write_en(we3),
    .ram_read_en(re3), .ram_addr(addr3), .ram_wdata(wd3), .cpu_hold(hold3), .done(done3),
    .error(err3), .word_count(wc3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic bit rdy(input bit s);
    return s ? rdy3 : rdy8;
  endfunction

  function automatic bit fin(input bit s);
    return s ? (done3 || err3) : (done8 || err8);
  endfunction

  function automatic logic [15:0] qword(input bit s, input int i);
    if (s) return (a3q.size() > i) ? d3q[i] : 16'hxxxx;
    return (d8q.size() > i) ? d8q[i] : 16'hxxxx;
  endfunction

  // capture every RAM write as the RAM would see it, and watch the fetch-path controls
  always @(negedge clk) if (!rst) begin
    if (we8) begin a8q.push_back(int'(addr8)); d8q.push_back(wd8); end
    if (we3) begin a3q.push_back(int'(addr3)); d3q.push_back(wd3); end
    chk("ram_enable", en8, 1);
    chk("ram_read_en", re8, !we8);
  end

  // stream-level reference: pair bytes into words, apply termination/overflow/checksum rules
  task automatic model(input int n, input int aw);
    int addr;
    logic [7:0] sum;
    bit full;
    ea.delete(); ed.delete(); e_done = 0; e_err = 0; addr = 0; sum = 0; full = 0;
    for (int i = 0; i < n; i += 2) begin
`ifdef LOADER_CHECKSUM_EN
      sum = sum + sb[i];
      if (sl[i]) begin e_done = (sum == 0); e_err = !e_done; return; end
      if (full) begin e_err = 1; return; end
      if (i + 1 >= n) return;
      sum = sum + sb[i+1];
      if (sl[i+1]) begin e_err = 1; return; end
      ea.push_back(addr); ed.push_back({sb[i], sb[i+1]});
      if (addr == (1 << aw) - 1) full = 1; else addr++;
`else
      if (sl[i]) begin e_err = 1; return; end
      if (i + 1 >= n) return;
      ea.push_back(addr); ed.push_back({sb[i], sb[i+1]});
      if (sl[i+1]) begin e_done = 1; return; end
      if (addr == (1 << aw) - 1) begin e_err = 1; return; end
      addr++;
`endif
    end
  endtask

  task automatic send_byte(input bit s, input logic [7:0] b, input bit l, input bit gap, output bit ok);
    int t;
    ok = 0;
    if (gap) begin byte_valid = 0; @(negedge clk); end
    byte_valid = 1; byte_data = b; byte_last = l;
    t = 0;
    while (!rdy(s) && !fin(s) && t < 40) begin @(negedge clk); t++; end
    if (rdy(s)) begin @(negedge clk); ok = 1; end
    else if (!fin(s)) begin
      checks++; errors++;
      $display("FAIL byte_ready_wait: got no ready in %0d cycles, required ready", t);
    end
    byte_valid = 0; byte_last = 0;
  endtask

  task automatic pulse_start(input bit s);
    @(negedge clk);
    if (s) start3 = 1; else start8 = 1;
    @(negedge clk);
    start3 = 0; start8 = 0;
  endtask

  task automatic finish_session(input bit s, input int n, input string tag);
    int t, nw;
    t = 0;
    while (!fin(s) && t < 20) begin @(negedge clk); t++; end
    if (!fin(s)) begin
      checks++; errors++;
      $display("FAIL %s:end_wait: got no done/error in %0d cycles, required one", tag, t);
    end
    repeat (4) @(negedge clk);
    model(n, s ? 3 : 8);
    nw = s ? a3q.size() : a8q.size();
    chk({tag, ":done"}, s ? done3 : done8, e_done);
    chk({tag, ":error"}, s ? err3 : err8, e_err);
    chk({tag, ":cpu_hold"}, s ? hold3 : hold8, 0);
    chk({tag, ":writes"}, nw, ea.size());
    chk({tag, ":word_count"}, s ? 32'(wc3) : 32'(wc8), ea.size());
    for (int i = 0; i < ea.size() && i < nw; i++) begin
      chk($sformatf("%s:addr%0d", tag, i), s ? a3q[i] : a8q[i], ea[i]);
      chk($sformatf("%s:data%0d", tag, i), qword(s, i), ed[i]);
    end
  endtask

  task automatic run_session(input bit s, input int n, input bit gap, input string tag);
    bit ok;
    a8q.delete(); d8q.delete(); a3q.delete(); d3q.delete();
    pulse_start(s);
    for (int i = 0; i < n; i++) begin
      if (fin(s)) break;
      send_byte(s, sb[i], sl[i], gap, ok);
      if (!ok) break;
    end
    finish_session(s, n, tag);
  endtask

  initial begin
    bit ok;
    int n, k, zeros;
    logic [7:0] sum;
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, s, gap;
    int n, k, zeros;
    logic [7:0] sum;
`ifdef LOADER_CHECKSUM_EN
    tbl.push_back('{3, 64'h2105DA0000000000, 8'h04, 0, 1, 0, 1, 16'h2105, 16'h0000});
    tbl.push_back('{3, 64'h2105DB0000000000, 8'h04, 0, 0, 1, 1, 16'h2105, 16'h0000});
    tbl.push_back('{4, 64'h210540FF00000000, 8'h08, 0, 0, 1, 1, 16'h2105, 16'h0000});
    tbl.push_back('{3, 64'h2105DA0000000000, 8'h04, 1, 1, 0, 1, 16'h2105, 16'h0000});
    tbl.push_back('{1, 64'h0000000000000000, 8'h01, 0, 1, 0, 0, 16'h0000, 16'h0000});
`else
    tbl.push_back('{4, 64'h210540FF00000000, 8'h08, 0, 1, 0, 2, 16'h2105, 16'h40FF});
    tbl.push_back('{4, 64'h210540FF00000000, 8'h08, 1, 1, 0, 2, 16'h2105, 16'h40FF});
    tbl.push_back('{3, 64'h1122330000000000, 8'h04, 0, 0, 1, 1, 16'h1122, 16'h0000});
    tbl.push_back('{1, 64'h7700000000000000, 8'h01, 0, 0, 1, 0, 16'h0000, 16'h0000});
    tbl.push_back('{6, 64'hF8010203040A0000, 8'h20, 1, 1, 0, 3, 16'hF801, 16'h0203});
`endif
    repeat (3) @(negedge clk);
    chk("rst:done", done8, 0);
    chk("rst:error", err8, 0);
    chk("rst:cpu_hold", hold8, 0);
    chk("rst:word_count", wc8, 0);
    chk("rst:ram_addr", addr8, 0);
    chk("rst:ram_wdata", wd8, 0);
    chk("rst:write_en", we8, 0);
    chk("rst:read_en", re8, 1);
    chk("rst:byte_ready", rdy8, 0);
    rst = 0;
    @(negedge clk);
    chk("idle:byte_ready", rdy8, 0);
    foreach (tbl[v]) begin
      for (int i = 0; i < tbl[v].n; i++) begin
        sb[i] = tbl[v].bytes[63-8*i -: 8];
        sl[i] = tbl[v].lastm[i];
      end
      run_session(0, tbl[v].n, tbl[v].gap, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d:tbl_done", v), done8, tbl[v].e_done);
      chk($sformatf("vec%0d:tbl_error", v), err8, tbl[v].e_err);
      chk($sformatf("vec%0d:tbl_wc", v), wc8, tbl[v].e_wc);
      if (tbl[v].e_wc > 0) chk($sformatf("vec%0d:tbl_w0", v), qword(0, 0), tbl[v].w0);
      if (tbl[v].e_wc > 1) chk($sformatf("vec%0d:tbl_w1", v), qword(0, 1), tbl[v].w1);
    end
    // overflow on a tiny RAM: ten words with no end marker
    for (int i = 0; i < 20; i++) begin sb[i] = 8'(i * 17 + 3); sl[i] = 0; end
    run_session(1, 20, 0, "ovf");
    chk("ovf:error", err3, 1);
    chk("ovf:writes", a3q.size(), 8);
    zeros = 0;
    foreach (a3q[i]) if (a3q[i] == 0) zeros++;
    chk("ovf:addr0_writes", zeros, 1);
    chk("ovf:ram0", qword(1, 0), 16'h0314);
    // start while loading must be ignored
    sb[0] = 8'h12; sb[1] = 8'h34; sb[2] = 8'h56; sb[3] = 8'h78;
    sl[0] = 0; sl[1] = 0; sl[2] = 0; sl[3] = 1;
    a8q.delete(); d8q.delete();
    pulse_start(0);
    send_byte(0, sb[0], sl[0], 0, ok);
    start8 = 1;
    send_byte(0, sb[1], sl[1], 0, ok);
    start8 = 0;
    send_byte(0, sb[2], sl[2], 0, ok);
    send_byte(0, sb[3], sl[3], 0, ok);
    finish_session(0, 4, "ign_start");
    // asynchronous reset while waiting for the low byte of word 2
    a8q.delete(); d8q.delete();
    pulse_start(0);
    send_byte(0, 8'hAA, 0, 0, ok);
    send_byte(0, 8'hBB, 0, 0, ok);
    send_byte(0, 8'hCC, 0, 0, ok);
    chk("mid:in_get_lo", rdy8, 1);
    #2 rst = 1;
    #1;
    chk("mid:cpu_hold", hold8, 0);
    chk("mid:byte_ready", rdy8, 0);
    chk("mid:word_count", wc8, 0);
    chk("mid:ram_addr", addr8, 0);
    chk("mid:ram_wdata", wd8, 0);
    chk("mid:write_en", we8, 0);
    chk("mid:read_en", re8, 1);
    chk("mid:done", done8, 0);
    chk("mid:error", err8, 0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    chk("mid:writes", a8q.size(), 1);
    chk("mid:ram0", qword(0, 0), 16'hAABB);
    // random streams
    for (int r = 0; r < 40; r++) begin
      s = (r % 5) == 4;
      gap = 1'($urandom_range(0, 1));
`ifdef LOADER_CHECKSUM_EN
      k = $urandom_range(0, s ? 10 : 6);
      sum = 0;
      for (int i = 0; i < 2 * k; i++) begin
        sb[i] = 8'($urandom); sl[i] = 0; sum = sum + sb[i];
      end
      sb[2*k] = 8'(0 - sum);
      if ($urandom_range(0, 3) == 0) sb[2*k] = sb[2*k] ^ 8'($urandom_range(1, 255));
      sl[2*k] = 1;
      n = 2 * k + 1;
`else
      n = $urandom_range(1, s ? 24 : 16);
      for (int i = 0; i < n; i++) begin sb[i] = 8'($urandom); sl[i] = (i == n - 1); end
`endif
      run_session(s, n, gap, $sformatf("rnd%0d", r));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
